// File: rtl/reset_sequencer_pkg.sv
// Shared definitions for the reset sequencer: state encodings for decoding
// state_o, default timing values and counter width.
package reset_sequencer_pkg;

  localparam int unsigned CNT_W         = 8;
  localparam int unsigned LOCK_FILT_DEF = 16;
  localparam int unsigned STAGE_DLY_DEF = 8;

  localparam logic [1:0] ST_WAIT_LOCK = 2'd0;
  localparam logic [1:0] ST_FILTER    = 2'd1;
  localparam logic [1:0] ST_RELEASE   = 2'd2;
  localparam logic [1:0] ST_RUN       = 2'd3;

  // Terminal count for a counter that must span `cycles` enabled cycles.
  function automatic logic [CNT_W-1:0] term_count(input int unsigned cycles);
    return CNT_W'(cycles - 1);
  endfunction

endpackage

// File: rtl/seq_delay_counter.sv
// Saturating up-counter with synchronous clear, enable and terminal-count flag;
// used for both the lock filter and the per-stage release delay.
module seq_delay_counter
  import reset_sequencer_pkg::*;
(
  input  logic             clk,
  input  logic             clr,
  input  logic             en,
  input  logic [CNT_W-1:0] term,
  output logic             tc_c
);

  logic [CNT_W-1:0] count;

  // Stops at term so the count never wraps; the owner clears it to restart.
  always_ff @(posedge clk) begin
    if (clr) begin
      count <= '0;
    end else if (en && !tc_c) begin
      count <= count + CNT_W'(1);
    end
  end

  assign tc_c = (count == term);

endmodule

// File: rtl/reset_sequencer.sv
// Releases NUM_DOMAINS resets in order once the clock source has been locked
// for LOCK_FILT cycles, spacing releases STAGE_DLY cycles apart.
module reset_sequencer
  import reset_sequencer_pkg::*;
#(
  parameter int unsigned NUM_DOMAINS  = 4,
  parameter logic        ACTIVE_STATE = 1'b0,
  parameter int unsigned LOCK_FILT    = LOCK_FILT_DEF,
  parameter int unsigned STAGE_DLY    = STAGE_DLY_DEF
) (
  input  logic                   clk,
  input  logic                   rst_i,
  input  logic                   clk_en,
  input  logic                   lock_i,
  input  logic                   sw_req_i,
  output logic [NUM_DOMAINS-1:0] rst_o,
  output logic                   done_o,
  output logic [1:0]             state_o
);

  localparam int unsigned SW = $clog2(NUM_DOMAINS) + 1;

  logic [1:0]             state;
  logic [1:0]             state_n;
  logic [SW-1:0]          stage;
  logic [SW-1:0]          stage_n;
  logic                   filt_clr;
  logic                   filt_en;
  logic                   filt_tc;
  logic                   dly_clr;
  logic                   dly_en;
  logic                   dly_tc;
  logic                   force_c;
  logic [NUM_DOMAINS-1:0] rel_n;
  logic                   done_n;
  logic [NUM_DOMAINS-1:0] rst_q  = {NUM_DOMAINS{ACTIVE_STATE}};
  logic                   done_q = 1'b0;

  seq_delay_counter u_filt_cnt (
    .clk  (clk),
    .clr  (filt_clr),
    .en   (filt_en),
    .term (term_count(LOCK_FILT)),
    .tc_c (filt_tc)
  );

  seq_delay_counter u_dly_cnt (
    .clk  (clk),
    .clr  (dly_clr),
    .en   (dly_en),
    .term (term_count(STAGE_DLY)),
    .tc_c (dly_tc)
  );

  // Next state; reset, lock loss and software restart bypass clk_en, lock loss first.
  always_comb begin
    state_n  = state;
    stage_n  = stage;
    filt_clr = 1'b0;
    filt_en  = 1'b0;
    dly_clr  = 1'b0;
    dly_en   = 1'b0;
    force_c  = 1'b0;
    if (rst_i || (state != ST_WAIT_LOCK && !lock_i)) begin
      state_n  = ST_WAIT_LOCK;
      stage_n  = '0;
      filt_clr = 1'b1;
      dly_clr  = 1'b1;
      force_c  = 1'b1;
    end else if (state != ST_WAIT_LOCK && sw_req_i) begin
      state_n  = ST_FILTER;
      stage_n  = '0;
      filt_clr = 1'b1;
      dly_clr  = 1'b1;
      force_c  = 1'b1;
    end else if (clk_en) begin
      case (state)
        ST_WAIT_LOCK: begin
          if (lock_i) begin
            state_n  = ST_FILTER;
            filt_clr = 1'b1;
          end
        end
        ST_FILTER: begin
          if (filt_tc) begin
            state_n = ST_RELEASE;
            stage_n = '0;
            dly_clr = 1'b1;
          end else begin
            filt_en = 1'b1;
          end
        end
        ST_RELEASE: begin
          if (stage == SW'(NUM_DOMAINS)) begin
            state_n = ST_RUN;
          end else if (dly_tc) begin
            stage_n = stage + SW'(1);
            dly_clr = 1'b1;
          end else begin
            dly_en = 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Release pattern derived from the current stage, so it lags entry to RELEASE by one cycle.
  always_comb begin
    rel_n = {NUM_DOMAINS{ACTIVE_STATE}};
    if (!force_c) begin
      for (int k = 0; k < NUM_DOMAINS; k++) begin
        if (state == ST_RUN || (state == ST_RELEASE && SW'(k) <= stage)) begin
          rel_n[k] = ~ACTIVE_STATE;
        end
      end
    end
    done_n = (state_n == ST_RUN);
  end

  always_ff @(posedge clk) begin
    if (rst_i) begin
      state  <= ST_WAIT_LOCK;
      stage  <= '0;
      rst_q  <= {NUM_DOMAINS{ACTIVE_STATE}};
      done_q <= 1'b0;
    end else begin
      state <= state_n;
      stage <= stage_n;
      if (force_c || clk_en) begin
        rst_q  <= rel_n;
        done_q <= done_n;
      end
    end
  end

  assign rst_o   = rst_q;
  assign done_o  = done_q;
  assign state_o = state;

endmodule

// File: tb/tb_reset_sequencer.sv
// Directed bench for reset_sequencer with default parameters (4 domains,
// 16-cycle lock filter, 8-cycle stage delay, active-low resets).
module tb_reset_sequencer;

  logic       clk = 1'b0;
  logic       rst_i;
  logic       clk_en;
  logic       lock_i;
  logic       sw_req_i;
  logic [3:0] rst_o;
  logic       done_o;
  logic [1:0] state_o;

  int checks = 0;
  int errors = 0;

  reset_sequencer #(
    .NUM_DOMAINS  (4),
    .ACTIVE_STATE (1'b0),
    .LOCK_FILT    (16),
    .STAGE_DLY    (8)
  ) dut (
    .clk      (clk),
    .rst_i    (rst_i),
    .clk_en   (clk_en),
    .lock_i   (lock_i),
    .sw_req_i (sw_req_i),
    .rst_o    (rst_o),
    .done_o   (done_o),
    .state_o  (state_o)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected {state_o, done_o, rst_o} d enabled edges after the accepted lock edge.
  function automatic logic [6:0] exp_vec(input int d);
    int n;
    logic [1:0] st;
    logic [3:0] r;
    if (d < 17) n = 0;
    else begin
      n = (d - 17) / 8 + 1;
      if (n > 4) n = 4;
    end
    r  = 4'((1 << n) - 1);
    st = (d < 16) ? 2'd1 : (d < 49) ? 2'd2 : 2'd3;
    return {st, (d >= 49), r};
  endfunction

  task automatic test_reset();
    rst_i = 1'b1; clk_en = 1'b1; lock_i = 1'b1; sw_req_i = 1'b1;
    #1;
    checks++;
    if ({done_o, rst_o} !== 5'b0_0000) begin
      errors++;
      $display("FAIL power_up got=%b exp=%b", {done_o, rst_o}, 5'b0_0000);
    end
    tick();
    tick();
    checks++;
    if ({state_o, done_o, rst_o} !== 7'b00_0_0000) begin
      errors++;
      $display("FAIL reset_hold got=%b exp=%b", {state_o, done_o, rst_o}, 7'b00_0_0000);
    end
    rst_i = 1'b0; sw_req_i = 1'b0;
  endtask

  task automatic test_nominal();
    for (int d = 0; d <= 49; d++) begin
      tick();
      checks++;
      if ({state_o, done_o, rst_o} !== exp_vec(d)) begin
        errors++;
        $display("FAIL nominal d=%0d got=%b exp=%b", d, {state_o, done_o, rst_o}, exp_vec(d));
      end
    end
  endtask

  task automatic test_lock_loss_run();
    clk_en = 1'b0; lock_i = 1'b0;
    tick();
    checks++;
    if ({state_o, done_o, rst_o} !== 7'b00_0_0000) begin
      errors++;
      $display("FAIL lock_loss_run got=%b exp=%b", {state_o, done_o, rst_o}, 7'b00_0_0000);
    end
    lock_i = 1'b1;
    tick();
    checks++;
    if ({state_o, done_o, rst_o} !== 7'b00_0_0000) begin
      errors++;
      $display("FAIL wait_clk_en got=%b exp=%b", {state_o, done_o, rst_o}, 7'b00_0_0000);
    end
  endtask

  task automatic test_lock_glitch();
    clk_en = 1'b1;
    for (int d = 0; d <= 10; d++) begin
      tick();
      checks++;
      if ({state_o, done_o, rst_o} !== exp_vec(d)) begin
        errors++;
        $display("FAIL glitch_pre d=%0d got=%b exp=%b", d, {state_o, done_o, rst_o}, exp_vec(d));
      end
    end
    lock_i = 1'b0;
    tick();
    checks++;
    if ({state_o, done_o, rst_o} !== 7'b00_0_0000) begin
      errors++;
      $display("FAIL glitch_drop got=%b exp=%b", {state_o, done_o, rst_o}, 7'b00_0_0000);
    end
    lock_i = 1'b1;
    for (int d = 0; d <= 49; d++) begin
      tick();
      checks++;
      if ({state_o, done_o, rst_o} !== exp_vec(d)) begin
        errors++;
        $display("FAIL glitch_restart d=%0d got=%b exp=%b", d, {state_o, done_o, rst_o}, exp_vec(d));
      end
    end
  endtask

  task automatic test_sw_req_release();
    lock_i = 1'b0;
    tick();
    lock_i = 1'b1;
    for (int d = 0; d <= 34; d++) begin
      tick();
      checks++;
      if ({state_o, done_o, rst_o} !== exp_vec(d)) begin
        errors++;
        $display("FAIL sw_pre d=%0d got=%b exp=%b", d, {state_o, done_o, rst_o}, exp_vec(d));
      end
    end
    sw_req_i = 1'b1;
    tick();
    sw_req_i = 1'b0;
    checks++;
    if ({state_o, done_o, rst_o} !== 7'b01_0_0000) begin
      errors++;
      $display("FAIL sw_release got=%b exp=%b", {state_o, done_o, rst_o}, 7'b01_0_0000);
    end
    for (int d = 1; d <= 49; d++) begin
      tick();
      checks++;
      if ({state_o, done_o, rst_o} !== exp_vec(d)) begin
        errors++;
        $display("FAIL sw_restart d=%0d got=%b exp=%b", d, {state_o, done_o, rst_o}, exp_vec(d));
      end
    end
  endtask

  task automatic test_clk_en_half();
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    for (int e = 0; e <= 98; e++) begin
      clk_en = (e % 2 == 0);
      tick();
      checks++;
      if ({state_o, done_o, rst_o} !== exp_vec(e / 2)) begin
        errors++;
        $display("FAIL half_en e=%0d got=%b exp=%b", e, {state_o, done_o, rst_o}, exp_vec(e / 2));
      end
    end
    clk_en = 1'b1;
  endtask

  task automatic test_rst_mid();
    lock_i = 1'b0;
    tick();
    lock_i = 1'b1;
    for (int d = 0; d <= 30; d++) begin
      tick();
      checks++;
      if ({state_o, done_o, rst_o} !== exp_vec(d)) begin
        errors++;
        $display("FAIL rst_mid_pre d=%0d got=%b exp=%b", d, {state_o, done_o, rst_o}, exp_vec(d));
      end
    end
    rst_i = 1'b1; clk_en = 1'b0;
    tick();
    checks++;
    if ({state_o, done_o, rst_o} !== 7'b00_0_0000) begin
      errors++;
      $display("FAIL rst_mid got=%b exp=%b", {state_o, done_o, rst_o}, 7'b00_0_0000);
    end
    rst_i = 1'b0; clk_en = 1'b1;
    for (int d = 0; d <= 49; d++) begin
      tick();
      checks++;
      if ({state_o, done_o, rst_o} !== exp_vec(d)) begin
        errors++;
        $display("FAIL rst_mid_post d=%0d got=%b exp=%b", d, {state_o, done_o, rst_o}, exp_vec(d));
      end
    end
  endtask

  task automatic test_sw_run_and_simultaneous();
    sw_req_i = 1'b1; clk_en = 1'b0;
    tick();
    sw_req_i = 1'b0;
    checks++;
    if ({state_o, done_o, rst_o} !== 7'b01_0_0000) begin
      errors++;
      $display("FAIL sw_run got=%b exp=%b", {state_o, done_o, rst_o}, 7'b01_0_0000);
    end
    clk_en = 1'b1;
    for (int d = 1; d <= 49; d++) begin
      tick();
      checks++;
      if ({state_o, done_o, rst_o} !== exp_vec(d)) begin
        errors++;
        $display("FAIL sw_run_post d=%0d got=%b exp=%b", d, {state_o, done_o, rst_o}, exp_vec(d));
      end
    end
    lock_i = 1'b0; sw_req_i = 1'b1;
    tick();
    sw_req_i = 1'b0;
    checks++;
    if ({state_o, done_o, rst_o} !== 7'b00_0_0000) begin
      errors++;
      $display("FAIL simultaneous got=%b exp=%b", {state_o, done_o, rst_o}, 7'b00_0_0000);
    end
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_lock_loss_run();
    test_lock_glitch();
    test_sw_req_release();
    test_clk_en_half();
    test_rst_mid();
    test_sw_run_and_simultaneous();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
